// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the two-port PSRAM channel-0 arbiter.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_WAIT = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  localparam logic       CMD_READ  = 1'b0;
  localparam logic       CMD_WRITE = 1'b1;
  localparam logic [3:0] MASK_NONE = 4'b1111;
  localparam logic [3:0] MASK_WORD = 4'b0011;

  // The 16-bit word rides in the upper half of the 32-bit IP bus, so only lanes 3:2 are ever enabled
  function automatic logic [3:0] write_mask(input logic is_byte, input logic a0);
    return is_byte ? {~a0, a0, 2'b11} : MASK_WORD;
  endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// Requester-side and PSRAM-IP-side signals of the arbiter, grouped in one bundle.
interface psram_arbiter_if;

  logic        p0_req;
  logic        p1_req;
  logic        p0_we;
  logic        p1_we;
  logic        p0_byte;
  logic        p1_byte;
  logic [21:0] p0_addr;
  logic [21:0] p1_addr;
  logic [15:0] p0_wdata;
  logic [15:0] p1_wdata;
  logic        p0_ack;
  logic        p1_ack;
  logic [15:0] p0_rdata;
  logic [15:0] p1_rdata;

  logic        cmd0;
  logic        cmd_en0;
  logic [20:0] addr0;
  logic [31:0] wr_data0;
  logic [3:0]  data_mask0;
  logic [31:0] rd_data0;
  logic        rd_data_valid0;

  modport master (
    input  p0_req, p1_req, p0_we, p1_we, p0_byte, p1_byte,
    input  p0_addr, p1_addr, p0_wdata, p1_wdata,
    output p0_ack, p1_ack, p0_rdata, p1_rdata,
    output cmd0, cmd_en0, addr0, wr_data0, data_mask0,
    input  rd_data0, rd_data_valid0
  );

  modport slave (
    output p0_req, p1_req, p0_we, p1_we, p0_byte, p1_byte,
    output p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  p0_ack, p1_ack, p0_rdata, p1_rdata,
    input  cmd0, cmd_en0, addr0, wr_data0, data_mask0,
    output rd_data0, rd_data_valid0
  );

endinterface

// File: rtl/psram_arb_pick.sv
// Combinational two-way picker: fixed priority to port 0, or round-robin away from the last winner.
module psram_arb_pick (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_prio,
  output logic       o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = 1'b0;
    case (i_req)
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = i_prio ? 1'b0 : ~i_last_grant;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/psram_arbiter.sv
// Shares PSRAM channel 0 between the CPU bridge (port 0) and the DMA engine (port 1),
// running one 16-bit read or write at a time in the IP user-clock domain.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter bit PRIO_P0     = 1'b0,
  parameter int BURST_BEATS = 4,
  parameter int WR_GAP      = 13,
  parameter int RD_TIMEOUT  = 63
) (
  input  logic            mclk,
  input  logic            rst_n,
  input  logic            init_calib,
  psram_arbiter_if.master bus,
  output logic            busy,
  output logic            rd_err
);

  localparam int CNT_MAX = (WR_GAP > RD_TIMEOUT) ? WR_GAP : RD_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  localparam logic [CW-1:0] WR_LAST   = CW'(WR_GAP - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_TIMEOUT - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_BEATS - 1);

  state_t        r_state;
  state_t        w_next;
  logic          w_take;
  logic          w_done;
  logic          w_timeout;
  logic          w_grant;
  logic          w_valid;
  logic          w_unused_lo;

  logic          r_sel;
  logic          r_last_grant;
  logic          r_we;
  logic          r_byte;
  logic [21:0]   r_addr;
  logic [15:0]   r_wdata;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_beat;
  logic          r_p0_ack;
  logic          r_p1_ack;
  logic [15:0]   r_p0_rdata;
  logic [15:0]   r_p1_rdata;
  logic          r_rd_err;

  psram_arb_pick u_pick (
    .i_req        ({bus.p1_req, bus.p0_req}),
    .i_last_grant (r_last_grant),
    .i_prio       (PRIO_P0),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // No grant in the ack cycle, so a requester that keeps req high is re-arbitrated with fresh fields
  always_comb begin
    w_next    = r_state;
    w_take    = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (init_calib && w_valid && !(r_p0_ack || r_p1_ack)) begin
          w_take = 1'b1;
          w_next = CMD;
        end
      end
      CMD: w_next = (r_we == CMD_WRITE) ? WR_WAIT : RD_WAIT;
      WR_WAIT: begin
        if (r_cnt == WR_LAST) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      RD_WAIT: begin
        if (bus.rd_data_valid0) begin
          if (r_beat == BEAT_LAST) begin
            w_done = 1'b1;
            w_next = IDLE;
          end
        end else if (r_beat == '0 && r_cnt == RD_LAST) begin
          w_timeout = 1'b1;
          w_done    = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= CMD_READ;
      r_byte       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_beat       <= '0;
      r_p0_ack     <= 1'b0;
      r_p1_ack     <= 1'b0;
      r_p0_rdata   <= '0;
      r_p1_rdata   <= '0;
      r_rd_err     <= 1'b0;
    end else begin
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_sel        <= w_grant;
            r_last_grant <= w_grant;
            r_we         <= w_grant ? bus.p1_we    : bus.p0_we;
            r_byte       <= w_grant ? bus.p1_byte  : bus.p0_byte;
            r_addr       <= w_grant ? bus.p1_addr  : bus.p0_addr;
            r_wdata      <= w_grant ? bus.p1_wdata : bus.p0_wdata;
          end
        end
        CMD: begin
          r_cnt  <= '0;
          r_beat <= '0;
        end
        WR_WAIT: r_cnt <= r_cnt + 1'b1;
        RD_WAIT: begin
          // The timeout only guards the first beat; once a burst has started it runs to completion
          if (bus.rd_data_valid0) begin
            if (r_beat == '0) begin
              if (r_sel) r_p1_rdata <= bus.rd_data0[31:16];
              else       r_p0_rdata <= bus.rd_data0[31:16];
            end
            r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + 1'b1;
          end else if (r_beat == '0) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_timeout) begin
            if (r_sel) r_p1_rdata <= 16'hFFFF;
            else       r_p0_rdata <= 16'hFFFF;
            r_rd_err <= 1'b1;
          end
        end
        default: ;
      endcase
      if (w_done) begin
        r_p0_ack <= ~r_sel;
        r_p1_ack <= r_sel;
      end
    end
  end

  assign w_unused_lo     = ^bus.rd_data0[15:0];

  assign bus.cmd_en0     = (r_state == CMD);
  assign bus.cmd0        = r_we ? CMD_WRITE : CMD_READ;
  assign bus.addr0       = r_addr[21:1];
  assign bus.wr_data0    = (r_state == CMD && r_we) ? {r_wdata, 16'h0000} : 32'h0;
  assign bus.data_mask0  = (r_state == CMD && r_we) ? write_mask(r_byte, r_addr[0]) : MASK_NONE;
  assign bus.p0_ack      = r_p0_ack;
  assign bus.p1_ack      = r_p1_ack;
  assign bus.p0_rdata    = r_p0_rdata;
  assign bus.p1_rdata    = r_p1_rdata;

  assign busy   = (r_state != IDLE);
  assign rd_err = r_rd_err;

endmodule
